// File: rtl/rs232_pkg.sv
// rs232_pkg: constants and FSM encoding shared by the RS-232 transmitter and receiver
package rs232_pkg;
  localparam logic [7:0] STX = 8'h02;
  localparam logic [7:0] ETX = 8'h03;
  localparam int BIT_CYCLES_DEF = 47;
  typedef enum logic [2:0] {IDLE, START_BIT, DATA_BIT, STOP_BIT, NEXT_BYTE, DONE} tx_state_t;
endpackage

// File: rtl/tx_packet_if.sv
// tx_packet_if: request/response bundle between a RAM read port and the packet transmitter
//   tx_start/addr/data_in : request, driven by master
//   tx_out/busy/done      : serial line and status, driven by slave
interface tx_packet_if;
  logic        tx_start;
  logic [6:0]  addr;
  logic [31:0] data_in;
  logic        tx_out;
  logic        busy;
  logic        done;
  modport master (output tx_start, addr, data_in, input tx_out, busy, done);
  modport slave  (input tx_start, addr, data_in, output tx_out, busy, done);
endinterface

// File: rtl/tx_packet.sv
// tx_packet: sends an 8-byte read-response packet (STX, addr, data LSB first, 00, ETX) as 8N1 serial
//   clk, rst : clock and asynchronous active-high reset
//   bus      : tx_packet_if slave (tx_start/addr/data_in in, tx_out/busy/done out)
module tx_packet
  import rs232_pkg::*;
#(
  parameter int BIT_CYCLES = BIT_CYCLES_DEF,
  parameter int PKT_BYTES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  tx_packet_if.slave bus
);
  localparam int TW = $clog2(BIT_CYCLES);
  localparam logic [2:0] LAST_BYTE = 3'(PKT_BYTES - 1);
  tx_state_t state, state_d;
  logic [TW-1:0] tmr, tmr_d;
  logic [2:0] bit_cnt, bit_cnt_d, byte_cnt, byte_cnt_d;
  logic [63:0] frame;
  logic [7:0] cur;
  logic accept, last, line_d, busy_d;
  // done is still high in the first IDLE cycle, so a request then is refused
  assign accept = state == IDLE && bus.tx_start && !bus.done;
  assign last   = tmr == TW'(BIT_CYCLES - 1);
  assign cur    = frame[{byte_cnt, 3'd0} +: 8];
  // NEXT_BYTE is never occupied: the byte decision is taken in the final stop-bit cycle
  always_comb begin
    state_d    = state;
    bit_cnt_d  = bit_cnt;
    byte_cnt_d = byte_cnt;
    tmr_d      = (state == IDLE || state == DONE || last) ? '0 : tmr + 1'b1;
    case (state)
      IDLE:      if (accept) begin state_d = START_BIT; byte_cnt_d = '0; end
      START_BIT: if (last) begin state_d = DATA_BIT; bit_cnt_d = '0; end
      DATA_BIT:  if (last) begin bit_cnt_d = bit_cnt + 1'b1; state_d = bit_cnt == 3'd7 ? STOP_BIT : DATA_BIT; end
      STOP_BIT:  if (last) begin
                   state_d    = byte_cnt == LAST_BYTE ? DONE : START_BIT;
                   byte_cnt_d = byte_cnt == LAST_BYTE ? byte_cnt : byte_cnt + 1'b1;
                 end
      DONE:      begin state_d = IDLE; byte_cnt_d = '0; end
      default:   state_d = IDLE;
    endcase
    // line and busy are registered one cycle behind the state they describe
    line_d = state == START_BIT ? 1'b0 : state == DATA_BIT ? cur[bit_cnt] : 1'b1;
    busy_d = state == IDLE ? accept : state != DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      tmr        <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      frame      <= '0;
      bus.tx_out <= 1'b1;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      state      <= state_d;
      tmr        <= tmr_d;
      bit_cnt    <= bit_cnt_d;
      byte_cnt   <= byte_cnt_d;
      if (accept) frame <= {ETX, 8'h00, bus.data_in, 1'b0, bus.addr, STX};
      bus.tx_out <= line_d;
      bus.busy   <= busy_d;
      bus.done   <= state == DONE;
    end
endmodule

// File: tb/tb_tx_packet.sv
// tb_tx_packet: directed self-checking bench for tx_packet with a sampling line decoder
module tb_tx_packet;
  logic clk = 0;
  logic rst;
  int errs = 0;
  int nchk = 0;
  int dones, done_off, bad_edges, busy_bad, first_fall, frame_bad, lows, busys;
  logic [63:0] got;
  logic bits [80];
  tx_packet_if bus();
  tx_packet #(.BIT_CYCLES(47), .PKT_BYTES(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run_pkt(input logic [6:0] a, input logic [31:0] d, input int m, input logic st,
                         input logic [6:0] ma, input logic [31:0] md);
    logic prev;
    dones = 0; done_off = -1; bad_edges = 0; busy_bad = 0; first_fall = -1; frame_bad = 0;
    @(negedge clk);
    bus.addr = a; bus.data_in = d; bus.tx_start = 1;
    prev = 1;
    for (int off = 0; off <= 3761; off++) begin
      @(negedge clk);
      if (off == 0) bus.tx_start = 0;
      if (off == m) begin bus.addr = ma; bus.data_in = md; bus.tx_start = st; end
      if (off == m + 1) bus.tx_start = 0;
      if (bus.tx_out !== prev) begin
        if (first_fall < 0) first_fall = off;
        if ((off - 1) % 47 != 0) bad_edges++;
      end
      prev = bus.tx_out;
      if (bus.done) begin dones++; done_off = off; end
      if (bus.busy !== (off <= 3760)) busy_bad++;
      if (off >= 1 && (off - 1) % 47 == 23) bits[(off - 1) / 47] = bus.tx_out;
    end
    for (int b = 0; b < 8; b++) begin
      if (bits[10*b] !== 1'b0 || bits[10*b+9] !== 1'b1) frame_bad++;
      for (int i = 0; i < 8; i++) got[8*b+i] = bits[10*b+1+i];
    end
  endtask
  initial begin
    rst = 1; bus.tx_start = 0; bus.addr = 0; bus.data_in = 0;
    repeat (3) @(negedge clk);
    chk("reset_tx_out", bus.tx_out, 1);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    rst = 0;
    @(negedge clk);
    chk("idle_line", bus.tx_out, 1);
    run_pkt(7'h15, 32'hDEADBEEF, 9999, 0, 0, 0);
    chk("nominal_frame", got, 64'h0300DEADBEEF1502);
    chk("nominal_framing", frame_bad, 0);
    chk("nominal_done_count", dones, 1);
    chk("nominal_done_cycle", done_off, 3761);
    chk("first_fall_cycle", first_fall, 1);
    chk("bit_width_edges", bad_edges, 0);
    chk("busy_window", busy_bad, 0);
    bus.tx_start = 1;
    @(negedge clk);
    bus.tx_start = 0;
    repeat (3) @(negedge clk);
    chk("start_with_done_busy", bus.busy, 0);
    chk("start_with_done_line", bus.tx_out, 1);
    run_pkt(7'h15, 32'hDEADBEEF, 500, 1, 7'h2A, 32'h12345678);
    chk("collision_frame", got, 64'h0300DEADBEEF1502);
    chk("collision_done_count", dones, 1);
    chk("collision_done_cycle", done_off, 3761);
    chk("collision_busy", busy_bad, 0);
    repeat (5) @(negedge clk);
    chk("collision_no_queue", bus.busy, 0);
    run_pkt(7'h15, 32'hDEADBEEF, 1, 0, 7'h15, 32'h0);
    chk("hold_frame", got, 64'h0300DEADBEEF1502);
    chk("hold_done_count", dones, 1);
    @(negedge clk);
    bus.addr = 7'h15; bus.data_in = 32'hDEADBEEF; bus.tx_start = 1;
    @(negedge clk);
    bus.tx_start = 0;
    repeat (1434) @(negedge clk);
    chk("byte3_start_low", bus.tx_out, 0);
    chk("byte3_busy", bus.busy, 1);
    rst = 1;
    #1;
    chk("abort_tx_out", bus.tx_out, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    @(negedge clk);
    rst = 0;
    lows = 0; busys = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.tx_out !== 1'b1) lows++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) busys++;
    end
    chk("post_reset_no_start", lows, 0);
    chk("post_reset_idle", busys, 0);
    run_pkt(7'h7F, 32'h00000001, 9999, 0, 0, 0);
    chk("loop_frame", got, 64'h0300000000017F02);
    chk("loop_stx", got[7:0], 8'h02);
    chk("loop_etx", got[63:56], 8'h03);
    chk("loop_framing", frame_bad, 0);
    chk("loop_done_cycle", done_off, 3761);
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule

// File: doc/tx_packet.md
TX_PACKET -- requirements
Module: tx_packet

Interface
REQ-001 Parameter BIT_CYCLES, default 47, clock cycles per serial bit; matches the receive-side 1-bit delay.
REQ-002 Parameter PKT_BYTES, default 8, bytes per packet; fixed at 8, with no other value supported.
REQ-003 clk  input  1  single system clock, rising-edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 tx_start  input  1  one-cycle request to send a read-response packet.
REQ-006 addr  input  7  RAM address being answered.
REQ-007 data_in  input  32  RAM read word (ram_out of receiver).
REQ-008 tx_out  output  1  RS-232 serial line, idle high.
REQ-009 busy  output  1  high from the accepted request until the last stop bit ends.
REQ-010 done  output  1  one-cycle pulse after the last stop bit of a packet.

Function
REQ-011 Packet byte order SHALL be: 0x02, {1'b0, addr}, data_in[7:0], data_in[15:8], data_in[23:16], data_in[31:24], 0x00, 0x03.
REQ-012 Each byte SHALL be framed as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1), with each bit held exactly BIT_CYCLES cycles.
REQ-013 Bytes SHALL be sent back-to-back with no extra idle between a stop bit and the next start bit.
REQ-014 A packet SHALL last exactly 80*BIT_CYCLES cycles (3760 at the default).
REQ-015 tx_start sampled high while idle SHALL latch addr and data_in into a 64-bit frame register in that cycle.
REQ-016 The start bit of byte 0 SHALL appear on tx_out on the first clock edge after the accepting edge (1-cycle latency).
REQ-017 tx_start while busy SHALL be ignored, with no queueing and no corruption of the packet in flight.
REQ-018 addr and data_in changes after acceptance SHALL NOT affect the transmitted packet.
REQ-019 FSM states SHALL be IDLE, START_BIT, DATA_BIT, STOP_BIT, NEXT_BYTE and DONE.
REQ-020 IDLE -> START_BIT on tx_start.
REQ-021 START_BIT -> DATA_BIT after BIT_CYCLES.
REQ-022 DATA_BIT -> STOP_BIT after the 8th bit period.
REQ-023 STOP_BIT -> NEXT_BYTE after BIT_CYCLES.
REQ-024 NEXT_BYTE -> START_BIT when the byte counter is below 7, otherwise -> DONE; NEXT_BYTE SHALL take 0 line cycles by being folded into the last stop-bit cycle.
REQ-025 DONE -> IDLE in one cycle, asserting done for that cycle only.
REQ-026 The bit-period counter SHALL count 0..BIT_CYCLES-1, then wrap, and be cleared on every state entry.
REQ-027 The bit counter SHALL be 3 bits wide; the byte counter SHALL be 3 bits wide, reaching 7 on the final byte with no overflow.
REQ-028 A tx_start coincident with done SHALL be ignored; a request is accepted only in IDLE.
REQ-029 tx_out and busy SHALL be registered outputs, with no combinational path from inputs to outputs.

Reset
REQ-030 rst SHALL asynchronously force state IDLE, tx_out=1, busy=0, done=0, and all counters and the frame register to 0.
REQ-031 rst during a packet SHALL abort it immediately, returning the line high with no partial stop bit emitted.
REQ-032 After rst deasserts, the first tx_start SHALL start a complete, fresh packet.

Structure
REQ-033 Shared package rs232_pkg SHALL hold the STX=8'h02, ETX=8'h03 and BIT_CYCLES default constants and the FSM state encoding, for reuse by the receiver.
REQ-034 One sub-module, uart_tx_byte, MAY serialise a single byte (start/data/stop plus bit timer) under a byte-level sequencer in tx_packet.

Verification
REQ-035 Reset: with rst high mid-byte-3, tx_out=1, busy=0 and done=0 SHALL hold in the same cycle; after release the line SHALL stay high with no spurious start bit.
REQ-036 Nominal: addr=7'h15, data_in=32'hDEADBEEF -> the decoded line SHALL be 02 15 EF BE AD DE 00 03, with done pulsing once at cycle 3761 after acceptance.
REQ-037 Bit timing: the first falling edge SHALL be 1 cycle after tx_start, and every bit SHALL be 47 cycles wide, checked via edge timestamps.
REQ-038 Busy collision: tx_start at cycle 500 with new data -> it SHALL be ignored, with the packet content unchanged and a single done pulse.
REQ-039 Input hold: change data_in to 0 one cycle after acceptance -> the original word SHALL still be transmitted.
REQ-040 Loopback: tx_out fed into the receiver with addr=7'h7F, data_in=32'h00000001 -> the receiver's frame check SHALL accept the 0x02 and 0x03 framing and recover the same 64-bit frame.
